// File: rtl/decode_stage_if.sv
// Decode-stage bus: upstream fetch handshake, flush, downstream control bundle and stats.
// Latency: none (wires only).
// Backpressure: carries in_ready/out_ready. slave = decode stage, master = its surroundings.
// Ports: in_valid/in_ready/in_instr/in_pc, flush, out_valid/out_ready, out_* decode bundle, bubble_count.
interface decode_stage_if #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_instr;
  logic [PC_WIDTH-1:0]  in_pc;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [PC_WIDTH-1:0]  out_pc;
  logic [31:0]          out_imm;
  logic [4:0]           out_rs1;
  logic [4:0]           out_rs2;
  logic [4:0]           out_rd;
  logic [2:0]           out_funct3;
  logic [6:0]           out_funct7;
  logic                 out_branch;
  logic                 out_jump;
  logic                 out_jump_src;
  logic [1:0]           out_alu_op;
  logic                 out_alu_src_a;
  logic [1:0]           out_alu_src_b;
  logic                 out_mem_read;
  logic                 out_mem_write;
  logic [1:0]           out_mem_data_mask;
  logic                 out_reg_write;
  logic [1:0]           out_reg_write_src;
  logic                 out_mul_div;
  logic                 out_illegal;
  logic [CNT_WIDTH-1:0] bubble_count;

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
           out_funct3, out_funct7, out_branch, out_jump, out_jump_src,
           out_alu_op, out_alu_src_a, out_alu_src_b, out_mem_read, out_mem_write,
           out_mem_data_mask, out_reg_write, out_reg_write_src, out_mul_div,
           out_illegal, bubble_count
  );

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
           out_funct3, out_funct7, out_branch, out_jump, out_jump_src,
           out_alu_op, out_alu_src_a, out_alu_src_b, out_mem_read, out_mem_write,
           out_mem_data_mask, out_reg_write, out_reg_write_src, out_mul_div,
           out_illegal, bubble_count
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I(+M) decode stage: registers one instruction with its control bundle and immediate.
// Latency: 1 cycle accept-to-valid; 1/cycle throughput, one bubble on load-use hazards.
// Backpressure: holds outputs while out_valid && !out_ready; in_ready drops on stall/hazard/flush.
// Ports: clk, rst (async, active-high), bus (decode_stage_if.slave) with all handshake/data signals.
module decode_stage #(
  parameter bit M_EXT     = 1'b0,
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  decode_stage_if.slave   bus
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

  typedef struct packed {
    logic        branch;
    logic        jump;
    logic        jump_src;
    logic [1:0]  alu_op;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_mask;
    logic        reg_write;
    logic [1:0]  wb_src;
    logic        mul_div;
    logic        illegal;
    logic [31:0] imm;
  } ctrl_t;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rs1_in;
  logic [4:0]  rs2_in;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        hazard;
  logic        in_ready_c;
  logic        accept;
  ctrl_t       dec;

  ctrl_t                ctrl_q;
  logic                 valid_q;
  logic [PC_WIDTH-1:0]  pc_q;
  logic [31:0]          instr_q;
  logic [CNT_WIDTH-1:0] bubble_q;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign rs1_in = instr[19:15];
  assign rs2_in = instr[24:20];

  assign uses_rs1 = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
  assign uses_rs2 = (opcode == OPC_OP || opcode == OPC_STORE || opcode == OPC_BRANCH);

  // Only a load still sitting in the output register can be too late to forward from.
  assign hazard = valid_q && ctrl_q.mem_read && (instr_q[11:7] != 5'd0) && bus.in_valid &&
                  ((uses_rs1 && rs1_in == instr_q[11:7]) || (uses_rs2 && rs2_in == instr_q[11:7]));

  assign in_ready_c = !bus.flush && !hazard && (!valid_q || bus.out_ready);
  assign accept     = bus.in_valid && in_ready_c;

  always_comb begin
    dec          = '0;
    dec.mem_mask = 2'b11;
    case (opcode)
      OPC_OP: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = 2'd2;
        dec.alu_src_b = 2'd0;
        if (f7 == 7'h00) begin
          dec.illegal = 1'b0;
        end else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
          dec.illegal = 1'b0;
        end else if (f7 == 7'h01 && M_EXT) begin
          dec.mul_div = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OPC_OPIMM: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = 2'd3;
        dec.alu_src_b = 2'd1;
        dec.imm       = {{20{instr[31]}}, instr[31:20]};
        if (f3 == 3'd1 && f7 != 7'h00) dec.illegal = 1'b1;
        if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) dec.illegal = 1'b1;
      end
      OPC_LOAD: begin
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
        dec.wb_src    = 2'd1;
        dec.alu_src_b = 2'd1;
        dec.imm       = {{20{instr[31]}}, instr[31:20]};
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) dec.illegal = 1'b1;
      end
      OPC_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src_b = 2'd1;
        dec.imm       = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        if (f3 > 3'd2) dec.illegal = 1'b1;
      end
      OPC_BRANCH: begin
        dec.branch = 1'b1;
        dec.alu_op = 2'd1;
        dec.imm    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        if (f3 == 3'd2 || f3 == 3'd3) dec.illegal = 1'b1;
      end
      OPC_JAL: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.wb_src    = 2'd2;
        dec.imm       = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_JALR: begin
        dec.jump      = 1'b1;
        dec.jump_src  = 1'b1;
        dec.alu_op    = 2'd3;
        dec.alu_src_b = 2'd1;
        dec.reg_write = 1'b1;
        dec.wb_src    = 2'd2;
        dec.imm       = {{20{instr[31]}}, instr[31:20]};
        if (f3 != 3'd0) dec.illegal = 1'b1;
      end
      OPC_LUI: begin
        dec.reg_write = 1'b1;
        dec.alu_src_a = 1'b1;
        dec.alu_src_b = 2'd1;
        dec.imm       = {instr[31:12], 12'h000};
      end
      OPC_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src_a = 1'b1;
        dec.alu_src_b = 2'd2;
        dec.imm       = {instr[31:12], 12'h000};
      end
      // Unknown opcode, including any encoding with instr[1:0] != 2'b11.
      default: dec.illegal = 1'b1;
    endcase

    // Memory access width only matters for loads/stores.
    if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
      case (f3)
        3'd0, 3'd4: dec.mem_mask = 2'b01;
        3'd1, 3'd5: dec.mem_mask = 2'b10;
        default:    dec.mem_mask = 2'b11;
      endcase
    end

    // Illegal instructions still flow downstream, but with every side effect suppressed.
    if (dec.illegal) begin
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
      dec.mul_div   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      pc_q     <= '0;
      instr_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (bus.flush) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end

      if (accept) begin
        ctrl_q  <= dec;
        pc_q    <= bus.in_pc;
        instr_q <= instr;
      end

      // The load leaves this cycle while the dependant is held back: one bubble follows.
      if (!bus.flush && hazard && valid_q && bus.out_ready && (bubble_q != '1)) begin
        bubble_q <= bubble_q + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.in_ready          = in_ready_c;
  assign bus.out_valid         = valid_q;
  assign bus.out_pc            = pc_q;
  assign bus.out_imm           = ctrl_q.imm;
  assign bus.out_rs1           = instr_q[19:15];
  assign bus.out_rs2           = instr_q[24:20];
  assign bus.out_rd            = instr_q[11:7];
  assign bus.out_funct3        = instr_q[14:12];
  assign bus.out_funct7        = instr_q[31:25];
  assign bus.out_branch        = ctrl_q.branch;
  assign bus.out_jump          = ctrl_q.jump;
  assign bus.out_jump_src      = ctrl_q.jump_src;
  assign bus.out_alu_op        = ctrl_q.alu_op;
  assign bus.out_alu_src_a     = ctrl_q.alu_src_a;
  assign bus.out_alu_src_b     = ctrl_q.alu_src_b;
  assign bus.out_mem_read      = ctrl_q.mem_read;
  assign bus.out_mem_write     = ctrl_q.mem_write;
  assign bus.out_mem_data_mask = ctrl_q.mem_mask;
  assign bus.out_reg_write     = ctrl_q.reg_write;
  assign bus.out_reg_write_src = ctrl_q.wb_src;
  assign bus.out_mul_div       = ctrl_q.mul_div;
  assign bus.out_illegal       = ctrl_q.illegal;
  assign bus.bubble_count      = bubble_q;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed RV32I vectors with hand-computed expectations.
// Two instances: default (M_EXT=0) and M_EXT=1, sharing clock and reset.
module tb_decode_stage;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  decode_stage_if #(.PC_WIDTH(32), .CNT_WIDTH(16)) if0 ();
  decode_stage_if #(.PC_WIDTH(32), .CNT_WIDTH(16)) if1 ();

  decode_stage #(.M_EXT(1'b0), .PC_WIDTH(32), .CNT_WIDTH(16)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  decode_stage #(.M_EXT(1'b1), .PC_WIDTH(32), .CNT_WIDTH(16)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0h want 0", if0.out_valid); end
    n_checks++; if (if0.bubble_count !== 16'd0) begin n_fail++; $display("FAIL rst_bubble: got %0h want 0", if0.bubble_count); end
    n_checks++; if (if0.out_mem_data_mask !== 2'b00) begin n_fail++; $display("FAIL rst_mask: got %0h want 0", if0.out_mem_data_mask); end
    n_checks++; if (if0.out_imm !== 32'd0) begin n_fail++; $display("FAIL rst_imm: got %0h want 0", if0.out_imm); end
    step();
    rst = 1'b0;
    #1;
    n_checks++; if (if0.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %0h want 1", if0.in_ready); end
    step();
    n_checks++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_out_valid: got %0h want 0", if0.out_valid); end
  endtask

  task automatic test_addi();
    if0.in_valid = 1'b1; if0.in_instr = 32'h00500093; if0.in_pc = 32'h100; if0.out_ready = 1'b1;
    #1;
    n_checks++; if (if0.in_ready !== 1'b1) begin n_fail++; $display("FAIL addi_in_ready: got %0h want 1", if0.in_ready); end
    step();
    if0.in_valid = 1'b0;
    n_checks++; if (if0.out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %0h want 1", if0.out_valid); end
    n_checks++; if (if0.out_imm !== 32'd5) begin n_fail++; $display("FAIL addi_imm: got %0h want 5", if0.out_imm); end
    n_checks++; if (if0.out_rd !== 5'd1) begin n_fail++; $display("FAIL addi_rd: got %0h want 1", if0.out_rd); end
    n_checks++; if (if0.out_reg_write !== 1'b1) begin n_fail++; $display("FAIL addi_reg_write: got %0h want 1", if0.out_reg_write); end
    n_checks++; if (if0.out_alu_op !== 2'd3) begin n_fail++; $display("FAIL addi_alu_op: got %0h want 3", if0.out_alu_op); end
    n_checks++; if (if0.out_alu_src_b !== 2'd1) begin n_fail++; $display("FAIL addi_src_b: got %0h want 1", if0.out_alu_src_b); end
    n_checks++; if (if0.out_illegal !== 1'b0) begin n_fail++; $display("FAIL addi_illegal: got %0h want 0", if0.out_illegal); end
    n_checks++; if (if0.out_pc !== 32'h100) begin n_fail++; $display("FAIL addi_pc: got %0h want 100", if0.out_pc); end
    step();
    n_checks++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got %0h want 0", if0.out_valid); end
  endtask

  task automatic test_load_use();
    if0.in_valid = 1'b1; if0.in_instr = 32'h0000A103; if0.in_pc = 32'h104; if0.out_ready = 1'b1;
    step();
    n_checks++; if (if0.out_valid !== 1'b1) begin n_fail++; $display("FAIL lw_valid: got %0h want 1", if0.out_valid); end
    n_checks++; if (if0.out_mem_read !== 1'b1) begin n_fail++; $display("FAIL lw_mem_read: got %0h want 1", if0.out_mem_read); end
    n_checks++; if (if0.out_reg_write_src !== 2'd1) begin n_fail++; $display("FAIL lw_wb_src: got %0h want 1", if0.out_reg_write_src); end
    n_checks++; if (if0.out_mem_data_mask !== 2'b11) begin n_fail++; $display("FAIL lw_mask: got %0h want 3", if0.out_mem_data_mask); end
    if0.in_instr = 32'h002101B3; if0.in_pc = 32'h108;
    #1;
    n_checks++; if (if0.in_ready !== 1'b0) begin n_fail++; $display("FAIL lu_hazard_in_ready: got %0h want 0", if0.in_ready); end
    step();
    n_checks++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble_valid: got %0h want 0", if0.out_valid); end
    n_checks++; if (if0.bubble_count !== 16'd1) begin n_fail++; $display("FAIL lu_bubble_count: got %0h want 1", if0.bubble_count); end
    n_checks++; if (if0.in_ready !== 1'b1) begin n_fail++; $display("FAIL lu_resume_ready: got %0h want 1", if0.in_ready); end
    step();
    if0.in_valid = 1'b0;
    n_checks++; if (if0.out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %0h want 1", if0.out_valid); end
    n_checks++; if (if0.out_rd !== 5'd3) begin n_fail++; $display("FAIL add_rd: got %0h want 3", if0.out_rd); end
    n_checks++; if (if0.out_pc !== 32'h108) begin n_fail++; $display("FAIL add_pc: got %0h want 108", if0.out_pc); end
    n_checks++; if (if0.out_alu_op !== 2'd2) begin n_fail++; $display("FAIL add_alu_op: got %0h want 2", if0.out_alu_op); end
    n_checks++; if (if0.out_imm !== 32'd0) begin n_fail++; $display("FAIL add_imm: got %0h want 0", if0.out_imm); end
    step();
  endtask

  task automatic test_jal_stall();
    if0.in_valid = 1'b1; if0.in_instr = 32'hFFDFF0EF; if0.in_pc = 32'h200; if0.out_ready = 1'b1;
    step();
    n_checks++; if (if0.out_imm !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL jal_imm: got %0h want fffffffc", if0.out_imm); end
    n_checks++; if (if0.out_jump !== 1'b1) begin n_fail++; $display("FAIL jal_jump: got %0h want 1", if0.out_jump); end
    n_checks++; if (if0.out_jump_src !== 1'b0) begin n_fail++; $display("FAIL jal_jump_src: got %0h want 0", if0.out_jump_src); end
    n_checks++; if (if0.out_reg_write_src !== 2'd2) begin n_fail++; $display("FAIL jal_wb_src: got %0h want 2", if0.out_reg_write_src); end
    if0.in_instr = 32'h00500093; if0.in_pc = 32'h204; if0.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (if0.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d]: got %0h want 0", i, if0.in_ready); end
      step();
      n_checks++; if (if0.out_valid !== 1'b1 || if0.out_imm !== 32'hFFFFFFFC || if0.out_pc !== 32'h200)
        begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%0h imm=%0h pc=%0h want v=1 imm=fffffffc pc=200", i, if0.out_valid, if0.out_imm, if0.out_pc); end
    end
    if0.out_ready = 1'b1;
    #1;
    n_checks++; if (if0.in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %0h want 1", if0.in_ready); end
    step();
    if0.in_valid = 1'b0;
    n_checks++; if (if0.out_imm !== 32'd5 || if0.out_pc !== 32'h204) begin n_fail++; $display("FAIL stall_next: got imm=%0h pc=%0h want imm=5 pc=204", if0.out_imm, if0.out_pc); end
    step();
  endtask

  task automatic test_mul();
    if0.in_valid = 1'b1; if0.in_instr = 32'h02208033; if0.in_pc = 32'h280; if0.out_ready = 1'b1;
    if1.in_valid = 1'b1; if1.in_instr = 32'h02208033; if1.in_pc = 32'h280; if1.out_ready = 1'b1;
    step();
    if0.in_valid = 1'b0; if1.in_valid = 1'b0;
    n_checks++; if (if0.out_valid !== 1'b1) begin n_fail++; $display("FAIL mul_m0_valid: got %0h want 1", if0.out_valid); end
    n_checks++; if (if0.out_illegal !== 1'b1) begin n_fail++; $display("FAIL mul_m0_illegal: got %0h want 1", if0.out_illegal); end
    n_checks++; if (if0.out_reg_write !== 1'b0) begin n_fail++; $display("FAIL mul_m0_reg_write: got %0h want 0", if0.out_reg_write); end
    n_checks++; if (if0.out_mul_div !== 1'b0) begin n_fail++; $display("FAIL mul_m0_mul_div: got %0h want 0", if0.out_mul_div); end
    n_checks++; if (if1.out_mul_div !== 1'b1) begin n_fail++; $display("FAIL mul_m1_mul_div: got %0h want 1", if1.out_mul_div); end
    n_checks++; if (if1.out_reg_write !== 1'b1) begin n_fail++; $display("FAIL mul_m1_reg_write: got %0h want 1", if1.out_reg_write); end
    n_checks++; if (if1.out_illegal !== 1'b0) begin n_fail++; $display("FAIL mul_m1_illegal: got %0h want 0", if1.out_illegal); end
    n_checks++; if (if1.out_alu_op !== 2'd2) begin n_fail++; $display("FAIL mul_m1_alu_op: got %0h want 2", if1.out_alu_op); end
    step();
  endtask

  task automatic test_flush_stall();
    if0.in_valid = 1'b1; if0.in_instr = 32'h0000A103; if0.in_pc = 32'h300; if0.out_ready = 1'b1;
    step();
    n_checks++; if (if0.out_valid !== 1'b1) begin n_fail++; $display("FAIL fl_lw_valid: got %0h want 1", if0.out_valid); end
    if0.in_instr = 32'h002101B3; if0.in_pc = 32'h304; if0.flush = 1'b1;
    #1;
    n_checks++; if (if0.in_ready !== 1'b0) begin n_fail++; $display("FAIL fl_in_ready: got %0h want 0", if0.in_ready); end
    step();
    if0.flush = 1'b0;
    n_checks++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_out_valid: got %0h want 0", if0.out_valid); end
    n_checks++; if (if0.bubble_count !== 16'd1) begin n_fail++; $display("FAIL fl_bubble_count: got %0h want 1", if0.bubble_count); end
    #1;
    n_checks++; if (if0.in_ready !== 1'b1) begin n_fail++; $display("FAIL fl_after_ready: got %0h want 1", if0.in_ready); end
    step();
    if0.in_valid = 1'b0;
    n_checks++; if (if0.out_valid !== 1'b1 || if0.out_pc !== 32'h304) begin n_fail++; $display("FAIL fl_add_late: got v=%0h pc=%0h want v=1 pc=304", if0.out_valid, if0.out_pc); end
    step();
  endtask

  task automatic test_back_to_back();
    if0.in_valid = 1'b1; if0.out_ready = 1'b1;
    if0.in_instr = 32'h0020A423; if0.in_pc = 32'h500;
    step();
    n_checks++; if (if0.out_imm !== 32'd8 || if0.out_mem_write !== 1'b1 || if0.out_reg_write !== 1'b0)
      begin n_fail++; $display("FAIL sw_ctrl: got imm=%0h mw=%0h rw=%0h want imm=8 mw=1 rw=0", if0.out_imm, if0.out_mem_write, if0.out_reg_write); end
    n_checks++; if (if0.out_alu_op !== 2'd0 || if0.out_alu_src_b !== 2'd1) begin n_fail++; $display("FAIL sw_alu: got op=%0h src_b=%0h want 0/1", if0.out_alu_op, if0.out_alu_src_b); end
    if0.in_instr = 32'hFE208CE3; if0.in_pc = 32'h504;
    step();
    n_checks++; if (if0.out_imm !== 32'hFFFFFFF8) begin n_fail++; $display("FAIL beq_imm: got %0h want fffffff8", if0.out_imm); end
    n_checks++; if (if0.out_branch !== 1'b1 || if0.out_alu_op !== 2'd1 || if0.out_pc !== 32'h504)
      begin n_fail++; $display("FAIL beq_ctrl: got br=%0h op=%0h pc=%0h want 1/1/504", if0.out_branch, if0.out_alu_op, if0.out_pc); end
    if0.in_instr = 32'h123452B7; if0.in_pc = 32'h508;
    step();
    n_checks++; if (if0.out_imm !== 32'h12345000) begin n_fail++; $display("FAIL lui_imm: got %0h want 12345000", if0.out_imm); end
    n_checks++; if (if0.out_alu_src_a !== 1'b1 || if0.out_alu_src_b !== 2'd1 || if0.out_reg_write !== 1'b1)
      begin n_fail++; $display("FAIL lui_ctrl: got a=%0h b=%0h rw=%0h want 1/1/1", if0.out_alu_src_a, if0.out_alu_src_b, if0.out_reg_write); end
    if0.in_instr = 32'hFFFFFFFF; if0.in_pc = 32'h50C;
    step();
    n_checks++; if (if0.out_valid !== 1'b1 || if0.out_illegal !== 1'b1 || if0.out_reg_write !== 1'b0)
      begin n_fail++; $display("FAIL bad_opc: got v=%0h ill=%0h rw=%0h want 1/1/0", if0.out_valid, if0.out_illegal, if0.out_reg_write); end
    if0.in_instr = 32'h0000A003; if0.in_pc = 32'h510;
    step();
    n_checks++; if (if0.out_mem_read !== 1'b1 || if0.out_rd !== 5'd0) begin n_fail++; $display("FAIL lw_x0: got mr=%0h rd=%0h want 1/0", if0.out_mem_read, if0.out_rd); end
    if0.in_instr = 32'h000001B3; if0.in_pc = 32'h514;
    #1;
    n_checks++; if (if0.in_ready !== 1'b1) begin n_fail++; $display("FAIL x0_no_hazard: got %0h want 1", if0.in_ready); end
    step();
    if0.in_valid = 1'b0;
    n_checks++; if (if0.out_pc !== 32'h514 || if0.bubble_count !== 16'd1)
      begin n_fail++; $display("FAIL x0_follow: got pc=%0h bub=%0h want 514/1", if0.out_pc, if0.bubble_count); end
    step();
  endtask

  task automatic test_async_reset();
    if0.in_valid = 1'b1; if0.in_instr = 32'h00500093; if0.in_pc = 32'h400; if0.out_ready = 1'b1;
    step();
    if0.in_valid = 1'b0;
    n_checks++; if (if0.out_valid !== 1'b1) begin n_fail++; $display("FAIL ar_pre_valid: got %0h want 1", if0.out_valid); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %0h want 0", if0.out_valid); end
    n_checks++; if (if0.out_imm !== 32'd0 || if0.out_pc !== 32'd0 || if0.out_reg_write !== 1'b0 || if0.out_alu_op !== 2'd0)
      begin n_fail++; $display("FAIL ar_outputs: got imm=%0h pc=%0h rw=%0h op=%0h want all 0", if0.out_imm, if0.out_pc, if0.out_reg_write, if0.out_alu_op); end
    n_checks++; if (if0.out_mem_data_mask !== 2'b00 || if0.bubble_count !== 16'd0)
      begin n_fail++; $display("FAIL ar_mask_bubble: got mask=%0h bub=%0h want 0/0", if0.out_mem_data_mask, if0.bubble_count); end
    #1;
    rst = 1'b0;
    step();
    n_checks++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_post_valid: got %0h want 0", if0.out_valid); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    if0.in_valid = 1'b0; if0.in_instr = 32'd0; if0.in_pc = 32'd0; if0.flush = 1'b0; if0.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.in_instr = 32'd0; if1.in_pc = 32'd0; if1.flush = 1'b0; if1.out_ready = 1'b0;
    test_reset();
    test_addi();
    test_load_use();
    test_jal_stall();
    test_mul();
    test_flush_stall();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
